// File: rtl/scene_compositor_pkg.sv
// scene_compositor_pkg: sequencer states and colour codes shared by the compositor
package scene_compositor_pkg;
  typedef enum logic [1:0] {PLAY = 2'd0, FLASH = 2'd1, HOLD = 2'd2} state_t;
  // {r,g,b} channel-on flags, expanded to COLOR_W bits per channel at the output register
  typedef enum logic [2:0] {
    BLACK = 3'b000,
    BLUE  = 3'b001,
    GREEN = 3'b010,
    RED   = 3'b100,
    WHITE = 3'b111
  } colour_t;
endpackage

// File: rtl/scene_compositor_obj_box_hit.sv
// obj_box_hit: inclusive rectangle hit test with clamped left edge and saturating right/bottom edges
module obj_box_hit #(
  parameter int W      = 10,
  parameter int X_LO   = 0,
  parameter int X_HI   = 16,
  parameter int Y_HI   = 16,
  parameter bit Y_OPEN = 1'b0
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] ox,
  input  logic [W-1:0] oy,
  output logic         hit
);
  localparam logic [W:0] XL = (W+1)'(X_LO);
  localparam logic [W:0] XH = (W+1)'(X_HI);
  localparam logic [W:0] YH = (W+1)'(Y_HI);
  // x + XL >= ox is the clamped left edge without a subtract that could wrap below zero
  assign hit = ({1'b0, x} + XL >= {1'b0, ox}) && ({1'b0, x} <= {1'b0, ox} + XH) &&
               (y >= oy) && (Y_OPEN || ({1'b0, y} <= {1'b0, oy} + YH));
endmodule

// File: rtl/scene_compositor.sv
// scene_compositor: per-pixel compositor with frame-latched objects and game-over flash sequencer
module scene_compositor
  import scene_compositor_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int COLOR_W      = 8,
  parameter int NUM_MTN      = 2,
  parameter int PLANE_X      = 80,
  parameter int PLANE_SZ     = 16,
  parameter int LAVA_SZ      = 16,
  parameter int MTN_HALF     = 25,
  parameter int SCORE_ROWS   = 8,
  parameter int SCORE_SCALE  = 2,
  parameter int FLASH_FRAMES = 16,
  parameter int FLASH_COUNT  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       bright,
  input  logic [COORD_W-1:0]         x,
  input  logic [COORD_W-1:0]         y,
  input  logic [COORD_W-1:0]         plane_y,
  input  logic [NUM_MTN*COORD_W-1:0] mountain_x,
  input  logic [NUM_MTN*COORD_W-1:0] mountain_y,
  input  logic [COORD_W-1:0]         lava_x,
  input  logic [COORD_W-1:0]         lava_y,
  input  logic                       game_over,
  input  logic [7:0]                 score,
  output logic [COLOR_W-1:0]         red,
  output logic [COLOR_W-1:0]         green,
  output logic [COLOR_W-1:0]         blue,
  output logic [1:0]                 state_dbg
);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int PW = $clog2(2 * FLASH_COUNT + 1);
  localparam int BW = COORD_W + 9;
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(2 * FLASH_COUNT - 1);
  state_t state;
  logic armed;
  logic [FW-1:0] frame_cnt;
  logic [PW-1:0] phase;
  logic [COORD_W-1:0] s_plane_y, s_lava_x, s_lava_y;
  logic [NUM_MTN*COORD_W-1:0] s_mtn_x, s_mtn_y;
  logic [7:0] s_score;
  logic [BW-1:0] bar_end;
  logic plane_hit, lava_hit, score_hit;
  logic [NUM_MTN-1:0] mtn_hit;
  logic s1_bright, s1_score, s1_plane, s1_lava, s1_red, s1_hold;
  logic [NUM_MTN-1:0] s1_mtn;
  colour_t pix;
  assign state_dbg = state;
  // Frame-synchronous sequencer; shadows only follow the inputs while playing so flash/hold freeze the scene
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= PLAY;
      armed     <= 1'b0;
      frame_cnt <= '0;
      phase     <= '0;
      s_plane_y <= '0;
      s_lava_x  <= '0;
      s_lava_y  <= '0;
      s_mtn_x   <= '0;
      s_mtn_y   <= '0;
      s_score   <= '0;
    end else if (frame_start) begin
      armed <= 1'b1;
      if (state == PLAY) begin
        s_plane_y <= plane_y;
        s_lava_x  <= lava_x;
        s_lava_y  <= lava_y;
        s_mtn_x   <= mountain_x;
        s_mtn_y   <= mountain_y;
        s_score   <= score;
      end
      if (!game_over) begin
        state     <= PLAY;
        frame_cnt <= '0;
        phase     <= '0;
      end else if (state == PLAY) begin
        state     <= FLASH;
        frame_cnt <= '0;
        phase     <= '0;
      end else if (state == FLASH) begin
        frame_cnt <= (frame_cnt == F_LAST) ? '0 : frame_cnt + 1'b1;
        if (frame_cnt == F_LAST) begin
          phase <= phase + 1'b1;
          if (phase == P_LAST) state <= HOLD;
        end
      end
    end
  obj_box_hit #(.W(COORD_W), .X_LO(0), .X_HI(PLANE_SZ), .Y_HI(PLANE_SZ), .Y_OPEN(1'b0)) u_plane (
    .x(x), .y(y), .ox(COORD_W'(PLANE_X)), .oy(s_plane_y), .hit(plane_hit)
  );
  obj_box_hit #(.W(COORD_W), .X_LO(0), .X_HI(LAVA_SZ), .Y_HI(LAVA_SZ), .Y_OPEN(1'b0)) u_lava (
    .x(x), .y(y), .ox(s_lava_x), .oy(s_lava_y), .hit(lava_hit)
  );
  for (genvar i = 0; i < NUM_MTN; i++) begin : g_mtn
    obj_box_hit #(.W(COORD_W), .X_LO(MTN_HALF), .X_HI(MTN_HALF), .Y_HI(0), .Y_OPEN(1'b1)) u_mtn (
      .x(x), .y(y), .ox(s_mtn_x[i*COORD_W +: COORD_W]), .oy(s_mtn_y[i*COORD_W +: COORD_W]),
      .hit(mtn_hit[i])
    );
  end
  assign bar_end   = BW'(s_score) * BW'(SCORE_SCALE);
  assign score_hit = ({9'd0, x} < bar_end) && (y < COORD_W'(SCORE_ROWS));
  // Stage 1: hit flags plus the display mode travelling with this pixel
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_bright <= 1'b0;
      s1_score  <= 1'b0;
      s1_plane  <= 1'b0;
      s1_mtn    <= '0;
      s1_lava   <= 1'b0;
      s1_red    <= 1'b0;
      s1_hold   <= 1'b0;
    end else begin
      s1_bright <= bright && armed;
      s1_score  <= score_hit;
      s1_plane  <= plane_hit;
      s1_mtn    <= mtn_hit;
      s1_lava   <= lava_hit;
      s1_red    <= (state == FLASH) && !phase[0];
      s1_hold   <= state == HOLD;
    end
  // Priority resolve: blanking, flash red, score, hold black, then scene objects
  always_comb
    pix = !s1_bright ? BLACK : s1_red ? RED : s1_score ? WHITE : s1_hold ? BLACK :
          s1_plane ? BLUE : (|s1_mtn) ? GREEN : s1_lava ? RED : BLACK;
  // Stage 2: registered colour channels
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= {COLOR_W{pix[2]}};
      green <= {COLOR_W{pix[1]}};
      blue  <= {COLOR_W{pix[0]}};
    end
endmodule
